dct2_4pt_pipe: RTL and testbench

- Pipelined 4-point 1D DCT-II (VVC integer kernel, coefficients 64/83/36) for one row or column of residual samples per beat.
- Sits in the dct2_2d datapath directly downstream of the input sample stage.
- Feeds its odd-part differences into the shared 83/36 shift-add unit.
- Produces four rounded, right-shifted, saturated coefficients per beat.
- Valid/ready on both sides; 3-stage pipeline.

---
 rtl/dct_pkg.sv | 51 +++++
 rtl/sau_2o_1.sv | 17 +
 rtl/dct2_4pt_pipe.sv | 125 ++++++++++++
 tb/tb_dct2_4pt_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants, widths and the round/clip helper for the 4-point DCT-II datapath.
package dct_pkg;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;
  localparam int C64_SH = $clog2(C64);

  localparam int IN_W   = 12;
  localparam int DIFF_W = 13;
  localparam int PROD_W = 20;
  localparam int ACC_W  = 21;
  localparam int VEC_W  = 16;

  typedef struct packed {
    logic signed [VEC_W-1:0] y0;
    logic signed [VEC_W-1:0] y1;
    logic signed [VEC_W-1:0] y2;
    logic signed [VEC_W-1:0] y3;
  } dct4_vec_t;

  typedef struct packed {
    logic                    sat;
    logic signed [VEC_W-1:0] val;
  } rss_t;

  // Round half up, floor shift in ACC_W+1 bits, then clip to out_w (out_w <= VEC_W).
  function automatic rss_t round_shift_sat(input logic signed [ACC_W-1:0] acc,
                                           input int shift, input int out_w);
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    rss_t res;
    one = (ACC_W+1)'(1);
    r   = ((ACC_W+1)'(acc) + (one <<< (shift - 1))) >>> shift;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    res.sat = 1'b0;
    if (r > hi) begin
      res.sat = 1'b1;
      r = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      r = lo;
    end
    res.val = r[VEC_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/sau_2o_1.sv
// Shared shift-add unit: 36*x and 83*x for a 13-bit signed odd-part difference.
module sau_2o_1
  import dct_pkg::*;
(
  input  logic signed [DIFF_W-1:0] x,
  output logic signed [PROD_W-1:0] p36,
  output logic signed [PROD_W-1:0] p83
);

  logic signed [PROD_W-1:0] xe;

  assign xe  = PROD_W'(x);
  // 83 = 64+16+2+1, 36 = 32+4
  assign p83 = (xe <<< 6) + (xe <<< 4) + (xe <<< 1) + xe;
  assign p36 = (xe <<< 5) + (xe <<< 2);

endmodule

// File: rtl/dct2_4pt_pipe.sv
// Three-stage 4-point integer DCT-II (64/83/36) with valid/ready and a single global stall enable.
module dct2_4pt_pipe #(
  parameter int IN_W  = 12,
  parameter int SHIFT = 3,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x0,
  input  logic signed [IN_W-1:0]  in_x1,
  input  logic signed [IN_W-1:0]  in_x2,
  input  logic signed [IN_W-1:0]  in_x3,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_y0,
  output logic signed [OUT_W-1:0] out_y1,
  output logic signed [OUT_W-1:0] out_y2,
  output logic signed [OUT_W-1:0] out_y3,
  output logic                    out_last,
  output logic                    out_sat
);
  import dct_pkg::*;

  logic en;
  logic vld_p0, vld_p1, vld_p2;
  logic last_p0, last_p1, last_p2;

  logic signed [DIFF_W-1:0] s0_p0, s1_p0, d0_p0, d1_p0;

  logic signed [ACC_W-1:0]  sum_c, dif_c;
  logic signed [PROD_W-1:0] p36d0_c, p83d0_c, p36d1_c, p83d1_c;
  logic signed [ACC_W-1:0]  e0_p1, e1_p1;
  logic signed [PROD_W-1:0] p36d0_p1, p83d0_p1, p36d1_p1, p83d1_p1;

  logic signed [ACC_W-1:0]  a_c [4];
  rss_t                     r_c [4];
  logic                     sat_c;
  logic signed [OUT_W-1:0]  y_p2 [4];
  logic                     sat_p2;

  // The whole pipe advances together; it only freezes when the output beat is held.
  assign en       = !vld_p2 || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
    end else if (en) begin
      vld_p0  <= in_valid;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      last_p0 <= in_last;
      last_p1 <= last_p0;
      last_p2 <= last_p1;
    end
  end

  // ---- stage 1: butterfly ----
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s0_p0 <= DIFF_W'(in_x0) + DIFF_W'(in_x3);
      s1_p0 <= DIFF_W'(in_x1) + DIFF_W'(in_x2);
      d0_p0 <= DIFF_W'(in_x0) - DIFF_W'(in_x3);
      d1_p0 <= DIFF_W'(in_x1) - DIFF_W'(in_x2);
    end
  end

  // ---- stage 2: even part scaled by 64, odd part through the shift-add units ----
  sau_2o_1 u_sau_d0 (.x(d0_p0), .p36(p36d0_c), .p83(p83d0_c));
  sau_2o_1 u_sau_d1 (.x(d1_p0), .p36(p36d1_c), .p83(p83d1_c));

  assign sum_c = ACC_W'(s0_p0) + ACC_W'(s1_p0);
  assign dif_c = ACC_W'(s0_p0) - ACC_W'(s1_p0);

  always_ff @(posedge clk) begin
    if (en && vld_p0) begin
      e0_p1    <= sum_c <<< C64_SH;
      e1_p1    <= dif_c <<< C64_SH;
      p36d0_p1 <= p36d0_c;
      p83d0_p1 <= p83d0_c;
      p36d1_p1 <= p36d1_c;
      p83d1_p1 <= p83d1_c;
    end
  end

  // ---- stage 3: odd combine, round, clip ----
  always_comb begin
    a_c[0] = e0_p1;
    a_c[1] = ACC_W'(p83d0_p1) + ACC_W'(p36d1_p1);
    a_c[2] = e1_p1;
    a_c[3] = ACC_W'(p36d0_p1) - ACC_W'(p83d1_p1);
    sat_c  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_c[i] = round_shift_sat(a_c[i], SHIFT, OUT_W);
      sat_c  = sat_c | r_c[i].sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) y_p2[i] <= '0;
      sat_p2 <= 1'b0;
    end else if (en && vld_p1) begin
      for (int i = 0; i < 4; i++) y_p2[i] <= OUT_W'(r_c[i].val);
      sat_p2 <= sat_c;
    end
  end

  assign out_valid = vld_p2;
  assign out_last  = last_p2;
  assign out_sat   = sat_p2;
  assign out_y0    = y_p2[0];
  assign out_y1    = y_p2[1];
  assign out_y2    = y_p2[2];
  assign out_y3    = y_p2[3];

endmodule

// File: tb/tb_dct2_4pt_pipe.sv
// Scoreboard bench for dct2_4pt_pipe: driver queues hand-computed results, a monitor checks each output beat.
module tb_dct2_4pt_pipe;
  import dct_pkg::*;

  typedef struct {
    dct4_vec_t y;
    logic      sat;
    logic      last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [IN_W-1:0] in_x0, in_x1, in_x2, in_x3;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic signed [15:0] out_y0, out_y1, out_y2, out_y3;
  logic out_last;
  logic out_sat;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  dct2_4pt_pipe #(.IN_W(12), .SHIFT(3), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3),
    .out_last(out_last), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int y0, input int y1, input int y2, input int y3,
                              input logic sat, input logic last);
    exp_t e;
    e.y.y0 = 16'(y0);
    e.y.y1 = 16'(y1);
    e.y.y2 = 16'(y2);
    e.y.y3 = 16'(y3);
    e.sat  = sat;
    e.last = last;
    return e;
  endfunction

  // Monitor: pops on every transferring beat; checks hold-stability across stalled cycles.
  logic held_v = 1'b0;
  logic signed [15:0] held_y0, held_y1, held_y2, held_y3;
  logic held_last, held_sat;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_y0", out_y0, held_y0);
        chk("hold_y1", out_y1, held_y1);
        chk("hold_y2", out_y2, held_y2);
        chk("hold_y3", out_y3, held_y3);
        chk("hold_last", out_last, held_last);
        chk("hold_sat", out_sat, held_sat);
      end
      held_v = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("y0", out_y0, e.y.y0);
            chk("y1", out_y1, e.y.y1);
            chk("y2", out_y2, e.y.y2);
            chk("y3", out_y3, e.y.y3);
            chk("sat", out_sat, e.sat);
            chk("last", out_last, e.last);
          end
        end else begin
          held_v    = 1'b1;
          held_y0   = out_y0;
          held_y1   = out_y1;
          held_y2   = out_y2;
          held_y3   = out_y3;
          held_last = out_last;
          held_sat  = out_sat;
        end
      end
    end
  end

  task automatic set_x(input int a, input int b, input int c, input int d);
    in_x0 = 12'(a);
    in_x1 = 12'(b);
    in_x2 = 12'(c);
    in_x3 = 12'(d);
  endtask

  task automatic send(input int a, input int b, input int c, input int d,
                      input logic lst, input exp_t e);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    set_x(a, b, c, d);
    in_last  = lst;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 20) begin
        chk("send_timeout", 1, 0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int   idx;
    int   c;
    int   k;
    int   n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    set_x(0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y0", out_y0, 0);
    chk("rst_out_y1", out_y1, 0);
    chk("rst_out_y2", out_y2, 0);
    chk("rst_out_y3", out_y3, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed single beats
    send(1, 1, 1, 1, 1'b0, mk(32, 0, 0, 0, 1'b0, 1'b0));
    send(100, 0, 0, -100, 1'b0, mk(0, 2075, 0, 900, 1'b0, 1'b0));
    send(-1, 0, 0, 1, 1'b0, mk(0, -21, 0, -9, 1'b0, 1'b0));
    send(2047, 2047, 2047, 2047, 1'b0, mk(32767, 0, 0, 0, 1'b1, 1'b0));
    send(-2048, -2048, -2048, -2048, 1'b0, mk(-32768, 0, 0, 0, 1'b1, 1'b0));
    send(2047, 2047, -2048, -2048, 1'b1, mk(-16, 32767, 0, -24058, 1'b1, 1'b1));
    drain();

    // 8-beat stream with out_ready low in cycles 5..7.
    // Even beats x=[8k,0,0,0] -> [64k,83k,64k,36k]; odd beats x=[0,8k,0,0] -> [64k,36k,-64k,-83k].
    idx = 0;
    c   = 0;
    while (idx < 8 && c < 60) begin
      k = idx + 1;
      if (idx % 2 == 0) set_x(8 * k, 0, 0, 0);
      else              set_x(0, 8 * k, 0, 0);
      in_valid  = 1'b1;
      in_last   = (idx == 7);
      out_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      if (c >= 5 && c <= 7) chk("stall_in_ready", in_ready, 0);
      if (in_ready) begin
        if (idx % 2 == 0) exp_q.push_back(mk(64 * k, 83 * k, 64 * k, 36 * k, 1'b0, idx == 7));
        else              exp_q.push_back(mk(64 * k, 36 * k, -64 * k, -83 * k, 1'b0, idx == 7));
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", idx, 8);
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      set_x(8, 0, 0, 0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) exp_q.push_back(mk(64, 83, 64, 36, 1'b0, 1'b0));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_drop_valid", out_valid, 0);
    chk("async_drop_y1", out_y1, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_beat", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(1, 1, 1, 1, 1'b1, mk(32, 0, 0, 0, 1'b0, 1'b1));
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("post_reset_latency", n, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
